// File: rtl/mfp_eic_priority_scheduler_pkg.sv
// Shared types and constants for the EIC priority scheduler slice.
package mfp_eic_priority_scheduler_pkg;

  localparam int unsigned EIC_PRIO_WIDTH = 3;
  localparam int unsigned EIC_CH_W       = 6;
  localparam int unsigned EIC_INT_W      = 8;
  localparam int unsigned EIC_OFF_W      = 17;
  localparam int unsigned EIC_SS_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACK    = 2'd2,
    ST_SETTLE = 2'd3
  } sched_state_e;

  // Vector offset in 2-byte units; wraps silently at 17 bits.
  function automatic logic [EIC_OFF_W-1:0] eic_offset(input logic [EIC_OFF_W-1:0] base,
                                                      input logic [EIC_CH_W-1:0]  ch,
                                                      input int unsigned          shift);
    return base + (EIC_OFF_W'(ch) << shift);
  endfunction

endpackage

// File: rtl/mfp_eic_prio_select.sv
// Combinational winner pick: highest level among eligible channels, ties resolved
// by scanning upward from rr_ptr with wrap-around.
module mfp_eic_prio_select
  import mfp_eic_priority_scheduler_pkg::*;
#(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned PRIO_WIDTH = EIC_PRIO_WIDTH
) (
  input  logic [CHANNELS-1:0]            eligible,
  input  logic [CHANNELS*PRIO_WIDTH-1:0] prio,
  input  logic [EIC_CH_W-1:0]            rr_ptr,
  output logic                           found,
  output logic [EIC_CH_W-1:0]            channel,
  output logic [PRIO_WIDTH-1:0]          level
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned POS_W = EIC_CH_W + 1;

  logic [PRIO_WIDTH-1:0] prio_arr [CHANNELS];
  logic [POS_W-1:0]      pos;
  logic [IDX_W-1:0]      idx;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign prio_arr[g] = prio[g*PRIO_WIDTH +: PRIO_WIDTH];
  end

  // Scan in rotated order; strict '>' keeps the first maximum seen from rr_ptr.
  always_comb begin
    found   = 1'b0;
    channel = '0;
    level   = '0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pos = POS_W'(rr_ptr) + POS_W'(k);
      if (pos >= POS_W'(CHANNELS)) pos = pos - POS_W'(CHANNELS);
      idx = IDX_W'(pos);
      if (eligible[idx] && (!found || (prio_arr[idx] > level))) begin
        found   = 1'b1;
        channel = EIC_CH_W'(idx);
        level   = prio_arr[idx];
      end
    end
  end

endmodule

// File: rtl/mfp_eic_priority_scheduler.sv
// EIC request scheduler: presents the winning channel to the CPU, runs the IAck
// handshake and pulses a one-hot clear back to the pending-register core.
module mfp_eic_priority_scheduler
  import mfp_eic_priority_scheduler_pkg::*;
#(
  parameter int unsigned           CHANNELS     = 8,
  parameter int unsigned           PRIO_WIDTH   = EIC_PRIO_WIDTH,
  parameter logic [EIC_OFF_W-1:0]  OFFSET_BASE  = 17'h100,
  parameter int unsigned           OFFSET_SHIFT = 4
) (
  input  logic                           CLK,
  input  logic                           RESETn,
  input  logic                           sched_enable,
  input  logic [CHANNELS-1:0]            pending,
  input  logic [CHANNELS-1:0]            mask,
  input  logic [CHANNELS*PRIO_WIDTH-1:0] prio,
  output logic [CHANNELS-1:0]            clear,
  output logic                           active_valid,
  output logic [EIC_CH_W-1:0]            active_channel,
  output logic [EIC_INT_W-1:0]           EIC_Interrupt,
  output logic [EIC_CH_W-1:0]            EIC_Vector,
  output logic [17:1]                    EIC_Offset,
  output logic [EIC_SS_W-1:0]            EIC_ShadowSet,
  output logic                           EIC_Present,
  input  logic                           EIC_IAck
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  sched_state_e              state_q, state_d;
  logic [EIC_CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [EIC_CH_W-1:0]       lat_ch_q, lat_ch_d;
  logic [PRIO_WIDTH-1:0]     lat_lvl_q, lat_lvl_d;
  logic [CHANNELS-1:0]       eligible;
  logic                      lat_eligible;
  logic                      sel_found;
  logic [EIC_CH_W-1:0]       sel_ch;
  logic [PRIO_WIDTH-1:0]     sel_lvl;
  logic                      present_d;
  logic [CHANNELS-1:0]       clear_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_elig
    assign eligible[g] = pending[g] & mask[g] & (|prio[g*PRIO_WIDTH +: PRIO_WIDTH]) & sched_enable;
  end

  assign lat_eligible = eligible[IDX_W'(lat_ch_q)];

  mfp_eic_prio_select #(
    .CHANNELS   (CHANNELS),
    .PRIO_WIDTH (PRIO_WIDTH)
  ) u_select (
    .eligible (eligible),
    .prio     (prio),
    .rr_ptr   (rr_ptr_q),
    .found    (sel_found),
    .channel  (sel_ch),
    .level    (sel_lvl)
  );

  // Next-state and latched-winner logic; IAck in REQ takes precedence over reselection.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lat_ch_d  = lat_ch_q;
    lat_lvl_d = lat_lvl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d   = ST_REQ;
          lat_ch_d  = sel_ch;
          lat_lvl_d = sel_lvl;
        end
      end
      ST_REQ: begin
        if (EIC_IAck) begin
          state_d = ST_ACK;
        end else if (!sel_found) begin
          state_d = ST_IDLE;
        end else if (!lat_eligible || (sel_lvl != lat_lvl_q)) begin
          lat_ch_d  = sel_ch;
          lat_lvl_d = sel_lvl;
        end
      end
      ST_ACK: begin
        state_d  = ST_SETTLE;
        rr_ptr_d = (lat_ch_q == EIC_CH_W'(CHANNELS - 1)) ? '0 : lat_ch_q + EIC_CH_W'(1);
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    present_d = (state_d == ST_REQ);
    clear_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clear_d[i] = (state_d == ST_ACK) && (lat_ch_d == EIC_CH_W'(i));
    end
  end

  // State plus every CPU-facing output registered from the next-state view.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      lat_ch_q       <= '0;
      lat_lvl_q      <= '0;
      clear          <= '0;
      active_valid   <= 1'b0;
      active_channel <= '0;
      EIC_Interrupt  <= '0;
      EIC_Vector     <= '0;
      EIC_Offset     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      lat_ch_q       <= lat_ch_d;
      lat_lvl_q      <= lat_lvl_d;
      clear          <= clear_d;
      active_valid   <= present_d;
      active_channel <= present_d ? lat_ch_d : '0;
      EIC_Interrupt  <= present_d ? EIC_INT_W'(lat_lvl_d) : '0;
      EIC_Vector     <= present_d ? lat_ch_d : '0;
      EIC_Offset     <= present_d ? eic_offset(OFFSET_BASE, lat_ch_d, OFFSET_SHIFT) : '0;
    end
  end

  assign EIC_ShadowSet = '0;
  assign EIC_Present   = 1'b1;

endmodule
